// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Requester side of the ALU interface. Issues one op per request,
//             waits out the ALU latency, and returns the tagged result.
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int          ALU_LATENCY = 1,
    parameter logic [3:0]  CMP_FUNC    = 4'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_func,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_dst,
    output logic        alu_en,
    output logic [3:0]  alu_func,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_out,
    input  logic        alu_cmp_lt,
    input  logic        alu_cmp_eq,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_dst,
    output logic        flag_lt,
    output logic        flag_eq
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic [2:0] c_CNT_INIT = 3'(ALU_LATENCY - 1);

    generate
        if (ALU_LATENCY < 1 || ALU_LATENCY > 7) begin : g_bad_latency
            $error("alu_sequencer: ALU_LATENCY must be in 1..7");
        end
    endgenerate

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [3:0]  func_q,  func_d;
    logic [15:0] a_q,     a_d;
    logic [15:0] b_q,     b_d;
    logic [3:0]  dst_q,   dst_d;
    logic [15:0] data_q,  data_d;
    logic        lt_q,    lt_d;
    logic        eq_q,    eq_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        dst_d   = dst_q;
        data_d  = data_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            c_ST_IDLE: begin
                if (req_valid) begin
                    func_d  = req_func;
                    a_d     = req_a;
                    b_d     = req_b;
                    dst_d   = req_dst;
                    state_d = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                cnt_d   = c_CNT_INIT;
                state_d = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // cnt reaches zero in the cycle the ALU result is valid
                if (cnt_q == 3'd0) begin
                    data_d = alu_out;
                    if (func_q == CMP_FUNC) begin
                        lt_d = alu_cmp_lt;
                        eq_d = alu_cmp_eq;
                    end
                    state_d = c_ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= 3'd0;
            func_q  <= 4'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            dst_q   <= 4'd0;
            data_q  <= 16'd0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign req_ready = (state_q == c_ST_IDLE);
    assign alu_en    = (state_q == c_ST_ISSUE);
    assign rsp_valid = (state_q == c_ST_RESP);
    assign alu_func  = func_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_data  = data_q;
    assign rsp_dst   = dst_q;
    assign flag_lt   = lt_q;
    assign flag_eq   = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Bench for alu_sequencer with a latency-accurate ALU stub and a
//             transaction-level reference model (latency 1 and latency 3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int         L1  = 1;
    localparam int         L3  = 3;
    localparam logic [3:0] CMP = 4'd4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] f_alu(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // ---------------- DUT with latency 1 ----------------
    logic        rv1 = 1'b0, rr1 = 1'b1;
    logic [3:0]  rf1 = 4'd0, rd1 = 4'd0;
    logic [15:0] ra1 = 16'd0, rb1 = 16'd0;
    logic        req_ready1, alu_en1, rsp_valid1, flag_lt1, flag_eq1, cmp_lt1, cmp_eq1;
    logic [3:0]  alu_func1, rsp_dst1;
    logic [15:0] alu_a1, alu_b1, alu_out1, rsp_data1;

    alu_sequencer #(.ALU_LATENCY(L1), .CMP_FUNC(CMP)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(rv1), .req_ready(req_ready1), .req_func(rf1), .req_a(ra1), .req_b(rb1), .req_dst(rd1),
        .alu_en(alu_en1), .alu_func(alu_func1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_out(alu_out1), .alu_cmp_lt(cmp_lt1), .alu_cmp_eq(cmp_eq1),
        .rsp_valid(rsp_valid1), .rsp_ready(rr1), .rsp_data(rsp_data1), .rsp_dst(rsp_dst1),
        .flag_lt(flag_lt1), .flag_eq(flag_eq1)
    );

    // ---------------- DUT with latency 3 ----------------
    logic        rv3 = 1'b0, rr3 = 1'b1;
    logic [3:0]  rf3 = 4'd0, rd3 = 4'd0;
    logic [15:0] ra3 = 16'd0, rb3 = 16'd0;
    logic        req_ready3, alu_en3, rsp_valid3, flag_lt3, flag_eq3, cmp_lt3, cmp_eq3;
    logic [3:0]  alu_func3, rsp_dst3;
    logic [15:0] alu_a3, alu_b3, alu_out3, rsp_data3;

    alu_sequencer #(.ALU_LATENCY(L3), .CMP_FUNC(CMP)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(rv3), .req_ready(req_ready3), .req_func(rf3), .req_a(ra3), .req_b(rb3), .req_dst(rd3),
        .alu_en(alu_en3), .alu_func(alu_func3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_out(alu_out3), .alu_cmp_lt(cmp_lt3), .alu_cmp_eq(cmp_eq3),
        .rsp_valid(rsp_valid3), .rsp_ready(rr3), .rsp_data(rsp_data3), .rsp_dst(rsp_dst3),
        .flag_lt(flag_lt3), .flag_eq(flag_eq3)
    );

    // ALU stubs: result valid only in the cycle exactly L after alu_en, junk otherwise
    logic [17:0] p1 [8];
    bit          pv1 [8];
    logic [17:0] p3 [8];
    bit          pv3 [8];

    always @(posedge clk) begin
        pv1[0] <= alu_en1;
        p1[0]  <= {alu_a1 < alu_b1, alu_a1 == alu_b1, f_alu(alu_func1, alu_a1, alu_b1)};
        pv3[0] <= alu_en3;
        p3[0]  <= {alu_a3 < alu_b3, alu_a3 == alu_b3, f_alu(alu_func3, alu_a3, alu_b3)};
        for (int i = 1; i < 8; i++) begin
            pv1[i] <= pv1[i-1];
            p1[i]  <= p1[i-1];
            pv3[i] <= pv3[i-1];
            p3[i]  <= p3[i-1];
        end
    end

    assign alu_out1 = pv1[L1-1] ? p1[L1-1][15:0] : 16'hDEAD;
    assign cmp_lt1  = pv1[L1-1] ? p1[L1-1][17]   : 1'b1;
    assign cmp_eq1  = pv1[L1-1] ? p1[L1-1][16]   : 1'b1;
    assign alu_out3 = pv3[L3-1] ? p3[L3-1][15:0] : 16'hDEAD;
    assign cmp_lt3  = pv3[L3-1] ? p3[L3-1][17]   : 1'b1;
    assign cmp_eq3  = pv3[L3-1] ? p3[L3-1][16]   : 1'b1;

    // Transaction model of dut1: one op in flight, timing derived from acceptance cycle
    bit          chk_en = 1'b0;
    bit          busy = 1'b0, seen = 1'b0, e_en, e_rv;
    int          acc = 0;
    logic [3:0]  m_func = 4'd0, m_dst = 4'd0;
    logic [15:0] m_a = 16'd0, m_b = 16'd0;
    logic        m_lt = 1'b0, m_eq = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            e_en = busy && (cyc == acc + 1);
            e_rv = busy && (cyc >= acc + 2 + L1);
            if (e_rv && !seen) begin
                seen = 1'b1;
                if (m_func == CMP) begin
                    m_lt = m_a < m_b;
                    m_eq = m_a == m_b;
                end
            end
            chk("m_req_ready", 32'(req_ready1), 32'(!busy));
            chk("m_alu_en",    32'(alu_en1),    32'(e_en));
            chk("m_rsp_valid", 32'(rsp_valid1), 32'(e_rv));
            chk("m_alu_func",  32'(alu_func1),  32'(m_func));
            chk("m_alu_a",     32'(alu_a1),     32'(m_a));
            chk("m_alu_b",     32'(alu_b1),     32'(m_b));
            chk("m_flag_lt",   32'(flag_lt1),   32'(m_lt));
            chk("m_flag_eq",   32'(flag_eq1),   32'(m_eq));
            if (e_rv) begin
                chk("m_rsp_data", 32'(rsp_data1), 32'(f_alu(m_func, m_a, m_b)));
                chk("m_rsp_dst",  32'(rsp_dst1),  32'(m_dst));
            end
            if (reset) begin
                busy = 1'b0; m_func = 4'd0; m_a = 16'd0; m_b = 16'd0;
                m_lt = 1'b0; m_eq = 1'b0;
            end else if (!busy && rv1) begin
                busy = 1'b1; acc = cyc; seen = 1'b0;
                m_func = rf1; m_a = ra1; m_b = rb1; m_dst = rd1;
            end else if (e_rv && rr1) begin
                busy = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send1(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d, input bit keep, output int tacc);
        rf1 = f; ra1 = a; rb1 = b; rd1 = d; rv1 = 1'b1;
        tacc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready1) begin tacc = cyc; break; end
        end
        if (tacc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got no req_ready expected acceptance within 50 cycles");
        end
        @(posedge clk); #1;
        if (!keep) rv1 = 1'b0;
    endtask

    // Returns at the negedge of the first rsp_valid cycle.
    task automatic wait_rsp1(output int tr);
        tr = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid1) begin tr = cyc; break; end
        end
        if (tr < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: got no rsp_valid expected response within 50 cycles");
        end
    endtask

    task automatic op3(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d, output int lat, output int ens);
        int t;
        rf3 = f; ra3 = a; rb3 = b; rd3 = d; rv3 = 1'b1;
        t = -1; lat = -1; ens = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready3) begin t = cyc; break; end
        end
        @(posedge clk); #1;
        rv3 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (alu_en3) ens++;
            if (rsp_valid3) begin lat = cyc - t; break; end
        end
        if (t < 0 || lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL op3_timeout: got no handshake expected completion within 50 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected completion before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tr, t1, t2, t3, lat, ens;

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready1), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("rst_alu_en",    32'(alu_en1),    32'd0);
        chk("rst_flags",     32'({flag_lt1, flag_eq1}), 32'd0);
        @(posedge clk); #1;

        // Single add, latency 1
        send1(4'd0, 16'h0003, 16'h0005, 4'd2, 1'b0, t);
        wait_rsp1(tr);
        chk("t2_latency", tr - t, 32'd3);
        chk("t2_data", 32'(rsp_data1), 32'h0008);
        chk("t2_dst",  32'(rsp_dst1),  32'd2);
        @(posedge clk); #1;

        // Compare updates flags; non-compare op leaves them alone
        send1(CMP, 16'h0002, 16'h0009, 4'd5, 1'b0, t);
        wait_rsp1(tr);
        chk("t3_cmp_data", 32'(rsp_data1), 32'h000B);
        @(posedge clk); #1;
        chk("t3_lt", 32'(flag_lt1), 32'd1);
        chk("t3_eq", 32'(flag_eq1), 32'd0);
        send1(4'd0, 16'h0005, 16'h0005, 4'd1, 1'b0, t);
        wait_rsp1(tr);
        chk("t3_add_data", 32'(rsp_data1), 32'h000A);
        @(posedge clk); #1;
        chk("t3_hold_lt", 32'(flag_lt1), 32'd1);
        chk("t3_hold_eq", 32'(flag_eq1), 32'd0);
        send1(CMP, 16'h0007, 16'h0007, 4'd6, 1'b0, t);
        wait_rsp1(tr);
        chk("t3_eq_data", 32'(rsp_data1), 32'h0000);
        @(posedge clk); #1;
        chk("t3_eq_flags", 32'({flag_lt1, flag_eq1}), 32'b01);

        // Reset held 2 cycles, asserted in the WAIT cycle
        send1(4'd0, 16'h1111, 16'h2222, 4'd9, 1'b0, t);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("t1_alu_en",    32'(alu_en1),    32'd0);
        chk("t1_flags",     32'({flag_lt1, flag_eq1}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t1_req_ready", 32'(req_ready1), 32'd1);
        chk("t1_no_rsp",    32'(rsp_valid1), 32'd0);
        @(posedge clk); #1;

        // Backpressure: response held 5 cycles, a pending request is not taken
        rr1 = 1'b0;
        send1(4'd2, 16'hF0F0, 16'h0FF0, 4'd7, 1'b0, t);
        wait_rsp1(tr);
        @(posedge clk); #1;
        rf1 = 4'd1; ra1 = 16'h0010; rb1 = 16'h0001; rd1 = 4'd3; rv1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_valid", 32'(rsp_valid1), 32'd1);
            chk("t4_data",  32'(rsp_data1),  32'h00F0);
            chk("t4_dst",   32'(rsp_dst1),   32'd7);
            chk("t4_ready", 32'(req_ready1), 32'd0);
            @(posedge clk); #1;
        end
        rr1 = 1'b1;
        send1(4'd1, 16'h0010, 16'h0001, 4'd3, 1'b0, t);
        wait_rsp1(tr);
        chk("t4_next_data", 32'(rsp_data1), 32'h000F);
        chk("t4_next_dst",  32'(rsp_dst1),  32'd3);
        @(posedge clk); #1;

        // Back-to-back with req_valid held
        send1(4'd0, 16'd100, 16'd23, 4'd1, 1'b1, t1);
        send1(4'd3, 16'hA000, 16'h0005, 4'd2, 1'b1, t2);
        send1(CMP, 16'h0009, 16'h0002, 4'd3, 1'b0, t3);
        chk("t5_gap12", t2 - t1, 32'd4);
        chk("t5_gap23", t3 - t2, 32'd4);
        wait_rsp1(tr);
        chk("t5_last_data", 32'(rsp_data1), 32'h000B);
        chk("t5_last_dst",  32'(rsp_dst1),  32'd3);
        @(posedge clk); #1;
        chk("t5_flags", 32'({flag_lt1, flag_eq1}), 32'b00);

        // Latency 3 instance
        op3(4'd0, 16'h1234, 16'h0101, 4'hC, lat, ens);
        chk("t6_latency", lat, 32'd5);
        chk("t6_en_cycles", ens, 32'd1);
        chk("t6_data", 32'(rsp_data3), 32'h1335);
        chk("t6_dst",  32'(rsp_dst3),  32'hC);
        @(posedge clk); #1;
        op3(CMP, 16'h0005, 16'h0005, 4'h4, lat, ens);
        chk("t6_cmp_latency", lat, 32'd5);
        chk("t6_cmp_data", 32'(rsp_data3), 32'h0000);
        @(posedge clk); #1;
        chk("t6_flags", 32'({flag_lt3, flag_eq3}), 32'b01);
        chk("t6_ready", 32'(req_ready3), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
